store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MIPS core's memory stage and the single-port data RAM. Stores from the core are queued in a small FIFO and drained to RAM in cycles the core does not use the RAM for a load; loads read RAM directly, with store-to-load forwarding from the youngest matching buffered store. It raises a stall request when a store or load cannot be serviced that cycle.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- core_we  in  1  store in M stage this cycle
- core_re  in  1  load in M stage this cycle; never high together with core_we
- core_addr  in  AW  byte address from the core; word index is core_addr[AW-1:2]
- core_wdata  in  DW  store data
- core_rdata  out  DW  load data, combinational, same cycle
- stall  out  1  core must hold M stage; current access is not consumed
- ram_we  out  1  RAM write strobe for this cycle
- ram_addr  out  AW  RAM address (load address or drained-store address)
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM asynchronous read data
- ram_ready  in  1  RAM accepts an access this cycle
- count  out  $clog2(DEPTH)+1  entries currently buffered

## Operation
- State: DEPTH entries {addr[AW-1:2], data}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count register.
- RAM port mux: core_re → ram_addr=core_addr, ram_we=0. Else if count>0 → ram_addr={head.addr,2'b00}, ram_wdata=head.data, ram_we=ram_ready. Else ram_we=0, ram_addr=core_addr.
- drain = ram_we (head entry retired at next edge).
- Store: push at edge when core_we && !stall. stall_st = core_we && count==DEPTH && !drain. Push and drain in the same cycle when full is legal; count unchanged.
- Load forwarding: compare core_addr[AW-1:2] against all valid entries; youngest (closest to tail) match wins. Hit → core_rdata=entry data, load never stalls. Miss → core_rdata=ram_rdata; stall_ld = core_re && !hit && !ram_ready.
- stall = stall_st | stall_ld. Stores to an address already buffered are appended (no merging); both drain in order.
- Word accesses only; no byte enables.
- Reset: count=0, head=tail=0, entries cleared; pending stores discarded. Outputs at reset: stall=0, ram_we=0, count=0, core_rdata=ram_rdata (miss path), ram_addr=core_addr.

## Timing
- Store latency: enqueued at edge N; earliest RAM write in cycle N+1 (ram_we high in that cycle, RAM commits at edge N+1→N+2 boundary per RAM).
- Load: zero-cycle, combinational through forward mux or RAM.
- A store pushed at edge N is visible to forwarding in cycle N+1.
- An entry draining in cycle N is still forwardable in cycle N (RAM not yet updated).
- Empty: no drain, ram_we=0. Full with ram_ready=0 and core_we: stall held every cycle until ram_ready.
- Async reset mid-drain: ram_we drops immediately with rst.

## Structure
- Package sbuf_pkg: DEPTH default, AW/DW, typedef sbuf_entry_t {addr, data}, pointer-width constant.
- Sub-module sbuf_fwd_match: combinational youngest-match priority search over entries given head/count; outputs hit and data.

## Test plan
- Reset then store 0x0000_0010←0xDEAD_BEEF with ram_ready=1 → count=1 next cycle; ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF following cycle; count returns 0.
- Store 0x20←0x1111, then 0x20←0x2222, ram_ready=0, load 0x20 → core_rdata=0x2222, stall=0.
- ram_ready=0, 4 stores to 0x0,0x4,0x8,0xC, 5th store 0x10 → stall=1 until ram_ready=1; then accepted same cycle 0x0 drains; RAM writes in order 0x0,0x4,0x8,0xC,0x10.
- Buffer holds 2 entries, continuous loads to unmatched address 0x100 for 3 cycles → ram_we=0 throughout, count stays 2, core_rdata=ram_rdata; drain resumes first non-load cycle.
- Load miss with ram_ready=0 → stall=1; ram_ready=1 → stall=0, data from RAM.
- Assert rst with 3 entries pending → count=0, ram_we=0 immediately; no further RAM writes after release.

Source files
------------

// File: rtl/sbuf_pkg.sv
// Store buffer shared types and defaults.
// Holds default geometry, pointer width and the entry layout.
package sbuf_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:2] addr;
    logic [SB_DW-1:0] data;
  } sbuf_entry_t;

endpackage

// File: rtl/sbuf_fwd_match.sv
// Youngest-match search over buffered stores for load forwarding.
// Ports: entAddr/entData (entries), head, cnt, matchAddr -> hit, data.
module sbuf_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic [AW-3:0] entAddr [DEPTH],
  input  logic [DW-1:0] entData [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] cnt,
  input  logic [AW-3:0] matchAddr,
  output logic          hit,
  output logic [DW-1:0] data
);

  // Walk oldest to youngest; later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt &&
          entAddr[head + PW'(i)] == matchAddr) begin
        hit  = 1'b1;
        data = entData[head + PW'(i)];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between core M stage and single-port data RAM.
// Ports: core_* (core side), ram_* (RAM side), stall, count.
module store_buffer
  import sbuf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     core_we,
  input  logic                     core_re,
  input  logic [AW-1:0]            core_addr,
  input  logic [DW-1:0]            core_wdata,
  output logic [DW-1:0]            core_rdata,
  output logic                     stall,
  output logic                     ram_we,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_wdata,
  input  logic [DW-1:0]            ram_rdata,
  input  logic                     ram_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] entAddr [DEPTH];
  logic [DW-1:0] entData [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic          notEmpty;
  logic          full;
  logic          drain;
  logic          push;
  logic          stallSt;
  logic          stallLd;
  logic          hit;
  logic [DW-1:0] fwdData;

  assign notEmpty = cnt != '0;
  assign full     = cnt == CW'(DEPTH);

  // Loads own the RAM port; otherwise drain the head when RAM is free.
  assign drain   = !core_re && notEmpty && ram_ready;
  assign ram_we  = drain;
  assign stallSt = core_we && full && !drain;
  assign stallLd = core_re && !hit && !ram_ready;
  assign stall   = stallSt | stallLd;
  assign push    = core_we && !stallSt;

  always_comb begin
    ram_addr = core_addr;
    if (!core_re && notEmpty)
      ram_addr = {entAddr[head], 2'b00};
  end

  assign ram_wdata  = entData[head];
  assign core_rdata = hit ? fwdData : ram_rdata;
  assign count      = cnt;

  sbuf_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW),
    .PW   (PW),
    .CW   (CW)
  ) uFwd (
    .entAddr  (entAddr),
    .entData  (entData),
    .head     (head),
    .cnt      (cnt),
    .matchAddr(core_addr[AW-1:2]),
    .hit      (hit),
    .data     (fwdData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entAddr[i] <= '0;
        entData[i] <= '0;
      end
    end else begin
      if (push) begin
        entAddr[tail] <= core_addr[AW-1:2];
        entData[tail] <= core_wdata;
        tail          <= tail + 1'b1;
      end
      if (drain)
        head <= head + 1'b1;
      unique case ({push, drain})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected RAM writes and load
// data are queued by stimulus and popped by a negedge monitor.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        stall;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic [2:0]  count;

  int nTests = 0;
  int nFail  = 0;

  logic [63:0] wQ [$];
  logic [31:0] ldQ [$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .core_we   (core_we),
    .core_re   (core_re),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .stall     (stall),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ready (ram_ready),
    .count     (count)
  );

  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk)
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write and every consumed load is scored.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        nTests++;
        if (wQ.size() == 0) begin
          nFail++;
          $display("FAIL unexpected_write: got %h<=%h expected none",
                   ram_addr, ram_wdata);
        end else begin
          logic [63:0] e;
          e = wQ.pop_front();
          if ({ram_addr, ram_wdata} !== e) begin
            nFail++;
            $display("FAIL ram_write: got %h<=%h expected %h<=%h",
                     ram_addr, ram_wdata, e[63:32], e[31:0]);
          end
        end
      end
      if (core_re && !stall) begin
        nTests++;
        if (ldQ.size() == 0) begin
          nFail++;
          $display("FAIL unexpected_load: got %h expected none",
                   core_rdata);
        end else begin
          logic [31:0] e;
          e = ldQ.pop_front();
          if (core_rdata !== e) begin
            nFail++;
            $display("FAIL load_data: got %h expected %h",
                     core_rdata, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    core_we    = 1'b1;
    core_re    = 1'b0;
    core_addr  = a;
    core_wdata = d;
  endtask

  task automatic idle();
    core_we   = 1'b0;
    core_re   = 1'b0;
    core_addr = 32'h44;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[17] = 32'h5555_0044;
    mem[64] = 32'hCAFE_0100;
    rst = 1'b1;
    ram_ready = 1'b0;
    core_wdata = '0;
    idle();
    #12;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h44);
    chk("rst_rdata", core_rdata, 32'h5555_0044);
    step();
    rst = 1'b0;
    step();

    // single store then drain
    ram_ready = 1'b1;
    store(32'h10, 32'hDEAD_BEEF);
    wQ.push_back({32'h10, 32'hDEAD_BEEF});
    #1 chk("st1_stall", {31'b0, stall}, 32'd0);
    step();
    idle();
    #1;
    chk("st1_count1", {29'b0, count}, 32'd1);
    chk("st1_ram_we", {31'b0, ram_we}, 32'd1);
    chk("st1_ram_addr", ram_addr, 32'h10);
    chk("st1_wdata", ram_wdata, 32'hDEAD_BEEF);
    step();
    chk("st1_count0", {29'b0, count}, 32'd0);
    chk("st1_we0", {31'b0, ram_we}, 32'd0);

    // two stores same address, forward youngest
    ram_ready = 1'b0;
    store(32'h20, 32'h1111);
    wQ.push_back({32'h20, 32'h1111});
    step();
    store(32'h20, 32'h2222);
    wQ.push_back({32'h20, 32'h2222});
    step();
    core_we = 1'b0;
    core_re = 1'b1;
    core_addr = 32'h20;
    ldQ.push_back(32'h2222);
    #1;
    chk("fwd_rdata", core_rdata, 32'h2222);
    chk("fwd_stall", {31'b0, stall}, 32'd0);
    chk("fwd_count", {29'b0, count}, 32'd2);
    step();

    // loads to unmatched address block the drain
    ram_ready = 1'b1;
    core_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      ldQ.push_back(32'hCAFE_0100);
      #1;
      chk("ldblk_we", {31'b0, ram_we}, 32'd0);
      chk("ldblk_count", {29'b0, count}, 32'd2);
      chk("ldblk_rdata", core_rdata, 32'hCAFE_0100);
      step();
    end
    idle();
    #1 chk("resume_we", {31'b0, ram_we}, 32'd1);
    step();
    step();
    chk("resume_count", {29'b0, count}, 32'd0);

    // load miss with RAM busy
    ram_ready = 1'b0;
    core_re = 1'b1;
    core_addr = 32'h10;
    #1 chk("miss_stall0", {31'b0, stall}, 32'd1);
    step();
    chk("miss_stall1", {31'b0, stall}, 32'd1);
    ldQ.push_back(32'hDEAD_BEEF);
    ram_ready = 1'b1;
    #1;
    chk("miss_release", {31'b0, stall}, 32'd0);
    chk("miss_rdata", core_rdata, 32'hDEAD_BEEF);
    step();
    idle();

    // fill to DEPTH, fifth store stalls
    ram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'(i * 4), 32'hA0 + 32'(i));
      wQ.push_back({32'(i * 4), 32'hA0 + 32'(i)});
      step();
    end
    store(32'h10, 32'hA4);
    wQ.push_back({32'h10, 32'hA4});
    #1;
    chk("full_stall0", {31'b0, stall}, 32'd1);
    chk("full_count", {29'b0, count}, 32'd4);
    step();
    chk("full_stall1", {31'b0, stall}, 32'd1);
    ram_ready = 1'b1;
    #1;
    chk("full_accept", {31'b0, stall}, 32'd0);
    chk("full_drain_addr", ram_addr, 32'h0);
    step();
    idle();
    #1 chk("full_count_same", {29'b0, count}, 32'd4);
    for (int i = 0; i < 10 && count != 0; i++) step();
    chk("full_drained", {29'b0, count}, 32'd0);
    chk("wq_empty", 32'(wQ.size()), 32'd0);

    // reset mid-drain discards pending stores
    ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h30 + 32'(i * 4), 32'hB0 + 32'(i));
      step();
    end
    idle();
    #1 chk("rst3_count", {29'b0, count}, 32'd3);
    ram_ready = 1'b1;
    #1 chk("rst3_draining", {31'b0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst3_we", {31'b0, ram_we}, 32'd0);
    chk("rst3_count0", {29'b0, count}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_count", {29'b0, count}, 32'd0);
    chk("ldq_empty", 32'(ldQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
